// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressed, word-organised data memory with sized
// loads/stores, alignment checking, a configurable read latency and a
// post-reset clear sequencer.
//
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready                          request handshake
//   req_write, req_size, req_unsigned            request kind
//   req_addr, req_wdata                          byte address, right-aligned store data
//   resp_valid, resp_data, resp_error            one pulse per accepted request
//   busy                                         clear sequence in progress
module sized_data_memory #(
    parameter int BitWidth    = 32,
    parameter int Capacity    = 128,
    parameter int ReadLatency = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [$clog2(Capacity)-1:0] req_addr,
    input  logic [BitWidth-1:0]         req_wdata,
    output logic                        resp_valid,
    output logic [BitWidth-1:0]         resp_data,
    output logic                        resp_error,
    output logic                        busy
);

    localparam int Bytes = BitWidth / 8;
    localparam int Words = Capacity / Bytes;
    localparam int AddrW = $clog2(Capacity);
    localparam int OffW  = $clog2(Bytes);
    localparam int IdxW  = $clog2(Words);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IdxW-1:0]   r_idx;
    logic [IdxW-1:0]   w_idx_nxt;

    logic [BitWidth-1:0] r_mem [Words];

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        req_ready   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            S_INIT: begin
                busy      = 1'b1;
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == IdxW'(Words - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic                w_acc;
    logic                w_clr;
    logic                w_bad_size;
    logic                w_misalign;
    logic                w_err;
    logic                w_wr;
    logic [IdxW-1:0]     w_widx;
    logic [OffW-1:0]     w_off;
    logic [7:0]          w_nbytes;
    logic [10:0]         w_nbits;
    logic [Bytes-1:0]    w_be_base;
    logic [Bytes-1:0]    w_be;
    logic [BitWidth-1:0] w_wshift;

    assign w_acc  = req_valid & req_ready;
    assign w_clr  = (r_state == S_INIT);
    assign w_widx = req_addr[AddrW-1:OffW];
    assign w_off  = req_addr[OffW-1:0];

    assign w_nbytes = 8'd1 << req_size;
    assign w_nbits  = {w_nbytes, 3'b000};

    assign w_bad_size = ({1'b0, req_size} > 3'(OffW));
    // Any set address bit below the access size means misaligned.
    assign w_misalign = |(req_addr & ~({AddrW{1'b1}} << req_size));
    assign w_err      = w_bad_size | w_misalign;
    assign w_wr       = w_acc & req_write & ~w_err;

    // Byte-enable: 2**size lanes starting at the byte offset.
    assign w_be_base = ~({Bytes{1'b1}} << w_nbytes);
    assign w_be      = w_be_base << w_off;
    assign w_wshift  = req_wdata << {w_off, 3'b000};

    // Array has no reset; it is cleared by the INIT sequence instead.
    always_ff @(posedge clock) begin
        if (w_clr) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < Bytes; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wshift[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Load path: read the array combinationally at accept so a store
    // committed on the previous edge is already visible.
    // ---------------------------------------------------------------
    logic [BitWidth-1:0] w_rword;
    logic [BitWidth-1:0] w_rshift;
    logic [BitWidth-1:0] w_mask;
    logic [BitWidth-1:0] w_top;
    logic                w_sign;
    logic [BitWidth-1:0] w_ldata;
    logic [BitWidth-1:0] w_resp_data;

    assign w_rword  = r_mem[w_widx];
    assign w_rshift = w_rword >> {w_off, 3'b000};
    // Shift by the full width yields zero, so a full-word mask is all ones.
    assign w_mask   = ~({BitWidth{1'b1}} << w_nbits);
    assign w_top    = w_mask & ~(w_mask >> 1);
    assign w_sign   = (|(w_rshift & w_top)) & ~req_unsigned;
    assign w_ldata  = (w_rshift & w_mask) | (w_sign ? ~w_mask : '0);

    assign w_resp_data = (w_acc & ~req_write & ~w_err) ? w_ldata : '0;

    // ---------------------------------------------------------------
    // Latency pipeline; idle stages carry zeros so outputs stay 0.
    // ---------------------------------------------------------------
    logic                r_pv [ReadLatency];
    logic                r_pe [ReadLatency];
    logic [BitWidth-1:0] r_pd [ReadLatency];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ReadLatency; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_acc;
            r_pe[0] <= w_acc & w_err;
            r_pd[0] <= w_resp_data;
            for (int i = 1; i < ReadLatency; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign resp_valid = r_pv[ReadLatency-1];
    assign resp_error = r_pe[ReadLatency-1];
    assign resp_data  = r_pd[ReadLatency-1];

endmodule
